// File: rtl/im_mem_stage.sv
// im_mem_stage: memory-access stage of the five-stage pipeline.
// Consumes the IX/IM register fields, runs loads/stores against the data
// memory over a req/ack handshake (big-endian lane steering, alignment
// check, ack timeout) and presents a registered result to IM/IW.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid, pc_in, O_in, B_in, access_size_in, rw_in,
//   memory_sign_extend_in, res_data_sel_in, rt_in, rd_in,
//   dest_reg_sel_in, write_to_reg_in      IX/IM fields
//   dmem_req/we/addr/be/wdata, dmem_ack/rdata   data-memory handshake
//   stall                       combinational upstream hold
//   out_valid, pc_out, result_out, dest_reg_out, write_to_reg_out,
//   align_err, bus_err          registered IM/IW outputs
module im_mem_stage #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] pc_in,
  input  logic [31:0] O_in,
  input  logic [31:0] B_in,
  input  logic [1:0]  access_size_in,
  input  logic        rw_in,
  input  logic        memory_sign_extend_in,
  input  logic        res_data_sel_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic        dest_reg_sel_in,
  input  logic        write_to_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] pc_out,
  output logic [31:0] result_out,
  output logic [4:0]  dest_reg_out,
  output logic        write_to_reg_out,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;

  // Fields captured when the request is issued
  logic [31:0] c_pc;
  logic [31:0] c_o;
  logic [1:0]  c_size;
  logic        c_store;
  logic        c_sext;
  logic [4:0]  c_dest;
  logic        c_wtr;

  logic        is_mem;
  logic        misalign;
  logic [4:0]  dest_sel;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  always_comb begin
    is_mem   = in_valid & (rw_in | res_data_sel_in);
    misalign = (access_size_in == 2'b11) ||
               (access_size_in == 2'b01 && O_in[0]) ||
               (access_size_in == 2'b00 && O_in[1:0] != 2'b00);
    dest_sel = dest_reg_sel_in ? rd_in : rt_in;
    stall    = (state == IDLE && is_mem && !misalign) ||
               (state == WAIT && !dmem_ack);
  end

  // Big-endian lane steering for the request being issued
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = B_in;
    case (access_size_in)
      2'b10: begin
        be_n    = 4'b1000 >> O_in[1:0];
        wdata_n = {4{B_in[7:0]}};
      end
      2'b01: begin
        be_n    = O_in[1] ? 4'b0011 : 4'b1100;
        wdata_n = {2{B_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction from the captured offset/size
  always_comb begin
    case (c_o[1:0])
      2'd0:    ld_byte = dmem_rdata[31:24];
      2'd1:    ld_byte = dmem_rdata[23:16];
      2'd2:    ld_byte = dmem_rdata[15:8];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = c_o[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    case (c_size)
      2'b10:   load_data = {{24{c_sext & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{c_sext & ld_half[15]}}, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      c_pc             <= '0;
      c_o              <= '0;
      c_size           <= '0;
      c_store          <= 1'b0;
      c_sext           <= 1'b0;
      c_dest           <= '0;
      c_wtr            <= 1'b0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_be          <= '0;
      dmem_wdata       <= '0;
      out_valid        <= 1'b0;
      pc_out           <= '0;
      result_out       <= '0;
      dest_reg_out     <= '0;
      write_to_reg_out <= 1'b0;
      align_err        <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem || misalign) begin
              // ALU result, or an access rejected before any request
              out_valid        <= 1'b1;
              pc_out           <= pc_in;
              result_out       <= O_in;
              dest_reg_out     <= dest_sel;
              write_to_reg_out <= write_to_reg_in & ~is_mem;
              align_err        <= is_mem;
            end else begin
              c_pc       <= pc_in;
              c_o        <= O_in;
              c_size     <= access_size_in;
              c_store    <= rw_in;
              c_sext     <= memory_sign_extend_in;
              c_dest     <= dest_sel;
              c_wtr      <= write_to_reg_in;
              dmem_req   <= 1'b1;
              dmem_we    <= rw_in;
              dmem_addr  <= {O_in[31:2], 2'b00};
              dmem_be    <= be_n;
              dmem_wdata <= rw_in ? wdata_n : '0;
              cnt        <= '0;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_ack || cnt == CNT_LAST) begin
            // Ack takes priority over a timeout in the same cycle
            out_valid        <= 1'b1;
            pc_out           <= c_pc;
            dest_reg_out     <= c_dest;
            write_to_reg_out <= dmem_ack & c_wtr;
            bus_err          <= ~dmem_ack;
            if (dmem_ack)
              result_out <= c_store ? c_o : load_data;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/im_mem_stage.md
# im_mem_stage

Memory-access (IM) stage of the five-stage pipeline. It sits directly downstream of the IX/IM pipeline register and consumes its latched fields: ALU result/address, store data, access size, read/write, sign-extend, result select, register specifiers and write-enable. It runs loads and stores against the data memory over a req/ack handshake, with big-endian byte-lane steering, alignment checking and a timeout, and stalls the upstream pipeline while an access is outstanding. It presents a registered result to the IM/IW pipeline register.

## Interface
- MEM_TIMEOUT, 15, number of WAIT cycles without `dmem_ack` before the access is aborted; legal range 1..255.

- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  the IX/IM register holds a valid instruction.
- pc_in  in  32  instruction PC.
- O_in  in  32  ALU result; the effective address for loads and stores.
- B_in  in  32  store data.
- access_size_in  in  2  00 = word, 01 = halfword, 10 = byte, 11 = reserved (always an alignment error).
- rw_in  in  1  1 = store.
- memory_sign_extend_in  in  1  1 = sign-extend a byte or halfword load.
- res_data_sel_in  in  1  1 = result comes from memory (load); 0 = result is O_in.
- rt_in  in  5  rt register specifier.
- rd_in  in  5  rd register specifier.
- dest_reg_sel_in  in  1  1 = destination is rd; 0 = destination is rt.
- write_to_reg_in  in  1  register-file write enable.
- dmem_req  out  1  access request; held high until ack or abort.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address, equal to {O[31:2], 2'b00}.
- dmem_be  out  4  byte enables; bit 3 selects bits 31:24.
- dmem_wdata  out  32  write data, replicated across lanes.
- dmem_ack  in  1  access complete; `dmem_rdata` is valid in the same cycle.
- dmem_rdata  in  32  read data.
- stall  out  1  combinational; upstream holds all `*_in` signals while it is high.
- out_valid  out  1  one-cycle pulse: the result registers hold a new instruction.
- pc_out  out  32  registered PC.
- result_out  out  32  registered writeback data.
- dest_reg_out  out  5  registered destination specifier (rd or rt, selected by `dest_reg_sel_in`).
- write_to_reg_out  out  1  registered write enable; forced to 0 on any error.
- align_err  out  1  one-cycle pulse alongside `out_valid`.
- bus_err  out  1  one-cycle pulse alongside `out_valid`.

## Operation
- A memory op is `in_valid & (rw_in | res_data_sel_in)`. A store has priority when both `rw_in` and `res_data_sel_in` are set.
- Misaligned conditions:
  - reserved access size (11);
  - halfword with O[0] = 1;
  - word with O[1:0] != 0.
- FSM has two states, IDLE and WAIT.
- IDLE, `in_valid` low: no action; `out_valid` = 0.
- IDLE, non-memory op: on posedge, register `pc`, `result = O_in`, `dest_reg` and `write_to_reg`; pulse `out_valid`.
- IDLE, misaligned memory op: no request is issued. On posedge, pulse `out_valid` and `align_err`; `write_to_reg_out` = 0; `result_out` = O_in.
- IDLE, aligned memory op: on posedge, capture all request fields internally, set `dmem_req` = 1, clear the timeout counter and go to WAIT.
- WAIT with `dmem_ack`:
  - a load formats `dmem_rdata` into `result_out`; a store sets `result_out` = O;
  - pulse `out_valid`, drop `dmem_req`, return to IDLE.
- WAIT with no ack: increment the counter. When the counter reaches MEM_TIMEOUT-1 with no ack:
  - drop `dmem_req`;
  - pulse `out_valid` and `bus_err`, with `write_to_reg_out` = 0;
  - return to IDLE.
- Ack and timeout in the same cycle: the ack wins.
- `stall` = (IDLE & aligned memory op) | (WAIT & ~dmem_ack).
- Store steering, big-endian (off = O[1:0]):
  - byte: wdata = {4{B[7:0]}}, be = 4'b1000 >> off;
  - half: wdata = {2{B[15:0]}}, be = 1100 if off = 0, 0011 if off = 2;
  - word: wdata = B, be = 1111.
- Load extraction:
  - byte lane off occupies rdata[31-8·off -: 8];
  - a halfword at off = 0 is rdata[31:16], at off = 2 is rdata[15:0];
  - zero- or sign-extend to 32 bits per `memory_sign_extend`;
  - a word load returns rdata unchanged.
- `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` come from the captured fields. They are 0 whenever `dmem_req` = 0.

## Timing
- Reset (async assert, sync release): state = IDLE and counter = 0. Every output is 0: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `out_valid`, `pc_out`, `result_out`, `dest_reg_out`, `write_to_reg_out`, `align_err`, `bus_err`. `stall` is 0 unless an aligned memory op is presented at the inputs.
- Reset during WAIT: `dmem_req` drops immediately and no `out_valid` is produced for the aborted access.
- Non-memory op: `out_valid` in cycle N+1 for `in_valid` in cycle N; no stall.
- Memory op presented in cycle N:
  - `stall` is high in cycle N;
  - `dmem_req` is high from cycle N+1;
  - an ack in cycle N+k (k ≥ 1) gives `out_valid` in cycle N+k+1;
  - `stall` is high for cycles N .. N+k-1 and low in cycle N+k.
- Minimum load/store latency is 2 cycles.
- `out_valid`, `align_err` and `bus_err` are single-cycle pulses. The result registers hold their values until the next `out_valid`.
- Downstream never back-pressures.

## Test plan
- ALU op, O = 0x0000_1234, `dest_reg_sel` = 1, rd = 5, `write_to_reg` = 1 -> next cycle: `out_valid`, `result_out` = 0x1234, `dest_reg_out` = 5; `stall` stays 0.
- Byte store, O = 0x101, B = 0xAB, ack 2 cycles after req -> `dmem_addr` = 0x100, `be` = 0100, `wdata` = 0xABABABAB, `we` = 1; `stall` high 2 cycles; `out_valid` follows.
- Halfword signed load, O = 0x202, rdata = 0x1234_8001 -> `result_out` = 0xFFFF_8001. Repeat with sign-extend = 0 -> 0x0000_8001. Byte load at off 0 with sign-extend = 0 -> 0x12.
- Word load, O = 0x302 -> no `dmem_req`; next cycle `out_valid` = 1, `align_err` = 1, `write_to_reg_out` = 0. Size 11 at O = 0 -> same response.
- Load with ack withheld, MEM_TIMEOUT = 4 -> `dmem_req` high exactly 4 cycles; then `bus_err` and `out_valid` pulse, `write_to_reg_out` = 0. Ack arriving in the 4th cycle instead -> normal completion, no `bus_err`.
- `rst_n` asserted mid-WAIT -> `dmem_req` = 0 immediately, all outputs 0, and no `out_valid` after release. A following ALU op completes normally.
